// File: rtl/ysyx_22041207_mem_arbiter.sv
// Shares one 64-bit memory port between instruction fetch and the load/store unit.
// One transaction is in flight at a time. LSU has priority, bounded by a starvation streak.
`timescale 1ns/1ps
module ysyx_22041207_mem_arbiter #(
   parameter int MAX_LS_STREAK = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        if_req,
   input  logic [63:0] if_addr,
   output logic        if_done,
   output logic [63:0] if_rdata,
   input  logic        ls_req,
   input  logic        ls_wen,
   input  logic [63:0] ls_addr,
   input  logic [63:0] ls_wdata,
   input  logic [7:0]  ls_wmask,
   output logic        ls_done,
   output logic [63:0] ls_rdata,
   output logic        mem_req,
   output logic        mem_wen,
   output logic [63:0] mem_addr,
   output logic [63:0] mem_wdata,
   output logic [7:0]  mem_wmask,
   input  logic        mem_ready,
   input  logic        mem_rvalid,
   input  logic [63:0] mem_rdata
);

   typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

   localparam logic [3:0] MAX_S = 4'(MAX_LS_STREAK);

   state_t     state, state_n;
   logic [3:0] streak;
   logic       owner;
   logic       grant_if, grant_ls;

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_n;
   end

   always_comb begin
      state_n  = state;
      grant_if = 1'b0;
      grant_ls = 1'b0;
      case (state)
         IDLE: begin
            // IF only wins a contended cycle once the LSU streak hits its cap
            if (ls_req && !(if_req && streak == MAX_S)) begin
               grant_ls = 1'b1;
               state_n  = REQ;
            end else if (if_req) begin
               grant_if = 1'b1;
               state_n  = REQ;
            end
         end
         REQ:     if (mem_ready) state_n = mem_wen ? RESP : WAIT;
         WAIT:    if (mem_rvalid) state_n = RESP;
         RESP:    state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         streak    <= 4'd0;
         owner     <= 1'b0;
         mem_req   <= 1'b0;
         mem_wen   <= 1'b0;
         mem_addr  <= 64'd0;
         mem_wdata <= 64'd0;
         mem_wmask <= 8'h00;
         if_done   <= 1'b0;
         ls_done   <= 1'b0;
         if_rdata  <= 64'd0;
         ls_rdata  <= 64'd0;
      end else begin
         if_done <= 1'b0;
         ls_done <= 1'b0;
         if (grant_ls) begin
            mem_req   <= 1'b1;
            mem_wen   <= ls_wen;
            mem_addr  <= ls_addr;
            mem_wdata <= ls_wdata;
            mem_wmask <= ls_wen ? ls_wmask : 8'h00;
            owner     <= 1'b1;
            if (!if_req)              streak <= 4'd0;
            else if (streak != MAX_S) streak <= streak + 4'd1;
         end else if (grant_if) begin
            mem_req   <= 1'b1;
            mem_wen   <= 1'b0;
            mem_addr  <= if_addr;
            mem_wdata <= 64'd0;
            mem_wmask <= 8'h00;
            owner     <= 1'b0;
            streak    <= 4'd0;
         end
         if (state == REQ && mem_ready) begin
            mem_req <= 1'b0;
            if (mem_wen) begin
               ls_done <= owner;
               if_done <= !owner;
            end
         end
         if (state == WAIT && mem_rvalid) begin
            if (owner) ls_rdata <= mem_rdata;
            else       if_rdata <= mem_rdata;
            ls_done <= owner;
            if_done <= !owner;
         end
      end
   end

endmodule

// File: tb/tb_ysyx_22041207_mem_arbiter.sv
// Bench for the IF/LSU memory arbiter: directed timing cases, then randomized traffic
// against a queue scoreboard, a byte-mask memory model and a rule-level grant model.
`timescale 1ns/1ps
module tb_ysyx_22041207_mem_arbiter;
   localparam int MAXS = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        if_req, if_done;
   logic [63:0] if_addr, if_rdata;
   logic        ls_req, ls_wen, ls_done;
   logic [63:0] ls_addr, ls_wdata, ls_rdata;
   logic [7:0]  ls_wmask;
   logic        mem_req, mem_wen, mem_ready, mem_rvalid;
   logic [63:0] mem_addr, mem_wdata, mem_rdata;
   logic [7:0]  mem_wmask;

   ysyx_22041207_mem_arbiter #(.MAX_LS_STREAK(MAXS)) dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_rdata(if_rdata),
      .ls_req(ls_req), .ls_wen(ls_wen), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
      .ls_wmask(ls_wmask), .ls_done(ls_done), .ls_rdata(ls_rdata),
      .mem_req(mem_req), .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_wmask(mem_wmask), .mem_ready(mem_ready), .mem_rvalid(mem_rvalid),
      .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   logic [63:0] mem  [logic [63:0]];
   logic [63:0] refm [logic [63:0]];
   logic [63:0] ifq [$];
   logic [63:0] lsq [$];
   logic        gq [$];
   logic [63:0] last_ls = 64'd0;

   // memory environment knobs
   bit rnd = 0;
   int spur = 0;
   bit stall = 0;
   int fix_rw = 0;
   int fix_rv = 0;
   logic rst_seen;
   always @(posedge clk) rst_seen <= rst;

   task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h t=%0t", nm, got, exp, $time);
      end
   endtask

   function automatic logic [63:0] init_val(input logic [63:0] a);
      if (a == 64'h8000_0000) return 64'h0000_0013_0000_0297;
      return {a[31:0] ^ 32'h5A5A_1234, ~a[31:0]};
   endfunction

   function automatic logic [63:0] merge(input logic [63:0] o, input logic [63:0] d,
                                         input logic [7:0] m);
      logic [63:0] r;
      r = o;
      for (int i = 0; i < 8; i++) if (m[i]) r[8*i +: 8] = d[8*i +: 8];
      return r;
   endfunction

   function automatic logic [63:0] mrd(input logic [63:0] a);
      return mem.exists(a) ? mem[a] : init_val(a);
   endfunction

   function automatic logic [63:0] rrd(input logic [63:0] a);
      return refm.exists(a) ? refm[a] : init_val(a);
   endfunction

   function automatic bit outs_zero();
      return !mem_req && !mem_wen && mem_addr == 64'd0 && mem_wdata == 64'd0 &&
             mem_wmask == 8'h00 && !if_done && !ls_done && if_rdata == 64'd0 &&
             ls_rdata == 64'd0;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // memory responder: drives ready/rvalid shortly after each rising edge
   initial begin : resp
      bit pend, hs, hw;
      int dly, cnt, crw;
      logic [63:0] ha, hd;
      logic [7:0]  hm;
      pend = 0; hs = 0; hw = 0; dly = 0; cnt = 0; crw = 0;
      ha = 0; hd = 0; hm = 0;
      mem_ready = 0; mem_rvalid = 0; mem_rdata = 0;
      forever begin
         tick();
         if (rst_seen) begin
            pend = 0; hs = 0; cnt = 0;
         end
         if (hs) begin
            if (hw) mem[ha] = merge(mrd(ha), hd, hm);
            else begin
               pend = 1;
               dly  = rnd ? int'($urandom_range(0, 5)) : fix_rv;
            end
            hs = 0; cnt = 0;
         end
         mem_ready  = 0;
         mem_rvalid = 0;
         mem_rdata  = {$urandom, $urandom};
         if (pend) begin
            if (dly == 0) begin
               mem_rvalid = 1;
               mem_rdata  = mrd(ha);
               pend = 0;
            end else dly--;
         end else if (mem_req && !stall) begin
            if (cnt == 0) crw = rnd ? int'($urandom_range(0, 3)) : fix_rw;
            mem_ready  = (cnt >= crw);
            mem_rvalid = (spur == 2) || (spur == 1 && $urandom_range(0, 1) == 1);
            cnt++;
            if (mem_ready) begin
               hs = 1; ha = mem_addr; hw = mem_wen; hd = mem_wdata; hm = mem_wmask;
            end
         end else begin
            mem_rvalid = (spur != 0) && ($urandom_range(0, 3) == 0);
         end
      end
   end

   // monitor: grant rule model, REQ stability, done pulses against the scoreboard
   initial begin : mon
      logic p_if, p_ls, p_lsw, p_mreq, p_rdy, p_ifd, p_lsd, p_mw, exp_ls, same;
      logic [63:0] p_ifa, p_lsa, p_ma, p_md, e;
      logic [7:0]  p_lsm, p_mm;
      int streak;
      p_if = 0; p_ls = 0; p_lsw = 0; p_mreq = 0; p_rdy = 0; p_ifd = 0; p_lsd = 0; p_mw = 0;
      p_ifa = 0; p_lsa = 0; p_ma = 0; p_md = 0; p_lsm = 0; p_mm = 0; streak = 0;
      forever begin
         @(negedge clk);
         if (rst) streak = 0;
         else begin
            if (mem_req && !p_mreq) begin
               exp_ls = p_ls && !(p_if && streak == MAXS);
               check("grant_addr", mem_addr, exp_ls ? p_lsa : p_ifa);
               check("grant_wen", 64'(mem_wen), 64'(exp_ls && p_lsw));
               check("grant_wmask", 64'(mem_wmask), (exp_ls && p_lsw) ? 64'(p_lsm) : 64'd0);
               if (exp_ls) streak = p_if ? ((streak < MAXS) ? streak + 1 : streak) : 0;
               else        streak = 0;
               gq.push_back(p_ls && mem_addr == p_lsa);
            end
            if (mem_req && p_mreq && !p_rdy) begin
               same = (mem_addr == p_ma) && (mem_wdata == p_md) && (mem_wmask == p_mm) &&
                      (mem_wen == p_mw);
               check("req_hold", 64'(same), 64'd1);
            end
            if (if_done) begin
               check("if_done_pulse", 64'(p_ifd), 64'd0);
               check("if_ls_excl", 64'(ls_done), 64'd0);
               if (ifq.size() == 0) check("if_done_unexp", 64'(if_done), 64'd0);
               else begin
                  e = ifq.pop_front();
                  check("if_rdata", if_rdata, e);
               end
            end
            if (ls_done) begin
               check("ls_done_pulse", 64'(p_lsd), 64'd0);
               if (lsq.size() == 0) check("ls_done_unexp", 64'(ls_done), 64'd0);
               else begin
                  e = lsq.pop_front();
                  check("ls_rdata", ls_rdata, e);
               end
            end
         end
         p_if = if_req; p_ifa = if_addr; p_ls = ls_req; p_lsa = ls_addr; p_lsw = ls_wen;
         p_lsm = ls_wmask; p_mreq = mem_req; p_rdy = mem_ready; p_ifd = if_done;
         p_lsd = ls_done; p_ma = mem_addr; p_md = mem_wdata; p_mm = mem_wmask; p_mw = mem_wen;
      end
   end

   task automatic ls_issue(input logic w, input logic [63:0] a, input logic [63:0] d,
                           input logic [7:0] m);
      ls_wen = w; ls_addr = a; ls_wdata = d; ls_wmask = m; ls_req = 1'b1;
      if (w) refm[a] = merge(rrd(a), d, m);
      else   last_ls = rrd(a);
      lsq.push_back(last_ls);
   endtask

   task automatic ls_wait();
      int c = 0;
      do begin tick(); c++; end while (!ls_done && c < 300);
      check("ls_wait", 64'(ls_done), 64'd1);
   endtask

   task automatic if_wait();
      int c = 0;
      do begin tick(); c++; end while (!if_done && c < 300);
      check("if_wait", 64'(if_done), 64'd1);
   endtask

   function automatic logic [7:0] pick_mask();
      case ($urandom_range(0, 3))
         0:       return 8'h01;
         1:       return 8'h0F;
         2:       return 8'hFF;
         default: return 8'($urandom);
      endcase
   endfunction

   task automatic do_ls(input int n, input int gap);
      for (int i = 0; i < n; i++) begin
         int k = (gap > 0) ? int'($urandom_range(0, gap)) : 0;
         repeat (k) begin ls_req = 1'b0; tick(); end
         ls_issue(1'($urandom_range(0, 1)), 64'h8000_1000 + 64'($urandom_range(0, 15)) * 8,
                  {$urandom, $urandom}, pick_mask());
         ls_wait();
      end
      ls_req = 1'b0;
   endtask

   task automatic do_if(input int n, input int gap);
      for (int i = 0; i < n; i++) begin
         int k = (gap > 0) ? int'($urandom_range(0, gap)) : 0;
         logic [63:0] a;
         repeat (k) begin if_req = 1'b0; tick(); end
         a = 64'h8000_0800 + 64'($urandom_range(0, 127)) * 8;
         if_addr = a; if_req = 1'b1;
         ifq.push_back(init_val(a));
         if_wait();
      end
      if_req = 1'b0;
   endtask

   initial begin : watchdog
      #400000;
      $display("FAIL watchdog timeout t=%0t", $time);
      $fatal(1);
   end

   initial begin : main
      rst = 1'b1; if_req = 0; if_addr = 0; ls_req = 0; ls_wen = 0; ls_addr = 0;
      ls_wdata = 0; ls_wmask = 0;
      repeat (3) tick();
      check("rst_hold_outs", 64'(outs_zero()), 64'd1);
      rst = 1'b0;
      tick();
      check("rst_idle_outs", 64'(outs_zero()), 64'd1);

      // reset while a fetch sits in REQ
      stall = 1;
      if_addr = 64'h8000_0040; if_req = 1'b1;
      tick();
      check("rst_req_seen", 64'(mem_req), 64'd1);
      tick();
      rst = 1'b1; if_req = 1'b0;
      tick();
      check("rst_mid_outs", 64'(outs_zero()), 64'd1);
      tick();
      check("rst_mid_outs2", 64'(outs_zero()), 64'd1);
      rst = 1'b0; stall = 0;
      repeat (4) tick();

      // zero-wait fetch
      fix_rw = 0; fix_rv = 0; spur = 0; rnd = 0;
      repeat (2) tick();
      if_addr = 64'h8000_0000; if_req = 1'b1;
      ifq.push_back(64'h0000_0013_0000_0297);
      tick();
      check("ifl_mem_req", 64'(mem_req), 64'd1);
      check("ifl_wmask", 64'(mem_wmask), 64'd0);
      tick();
      check("ifl_wait_noreq", 64'(mem_req), 64'd0);
      tick();
      check("ifl_done", 64'(if_done), 64'd1);
      check("ifl_rdata", if_rdata, 64'h0000_0013_0000_0297);
      check("ifl_ls_quiet", 64'(ls_done), 64'd0);
      if_req = 1'b0;
      tick();
      check("ifl_done_off", 64'(if_done), 64'd0);
      repeat (2) tick();

      // store held off by three cycles of backpressure
      fix_rw = 3;
      repeat (2) tick();
      ls_issue(1'b1, 64'h8000_0100, 64'h0000_0000_DEAD_BEEF, 8'h0F);
      for (int i = 0; i < 4; i++) begin
         tick();
         check("st_req", 64'(mem_req), 64'd1);
         check("st_addr", mem_addr, 64'h8000_0100);
         check("st_wdata", mem_wdata, 64'h0000_0000_DEAD_BEEF);
         check("st_wmask", 64'(mem_wmask), 64'h0F);
         check("st_done_early", 64'(ls_done), 64'd0);
      end
      tick();
      check("st_done", 64'(ls_done), 64'd1);
      ls_req = 1'b0;
      tick();
      check("st_done_off", 64'(ls_done), 64'd0);
      repeat (2) tick();

      // slow read with rvalid pulses during REQ
      fix_rw = 2; fix_rv = 5; spur = 2;
      repeat (2) tick();
      ls_issue(1'b0, 64'h8000_0100, 64'd0, 8'h00);
      for (int i = 1; i < 10; i++) begin
         tick();
         check("slow_no_done", 64'(ls_done), 64'd0);
      end
      tick();
      check("slow_done", 64'(ls_done), 64'd1);
      ls_req = 1'b0;
      repeat (3) tick();

      // back-to-back from the same requester
      fix_rw = 0; fix_rv = 0; spur = 0;
      repeat (2) tick();
      ls_issue(1'b1, 64'h8000_1008, {$urandom, $urandom}, 8'hFF);
      ls_wait();
      ls_issue(1'b0, 64'h8000_1008, 64'd0, 8'h00);
      tick();
      check("b2b_gap", 64'(mem_req), 64'd0);
      tick();
      check("b2b_req", 64'(mem_req), 64'd1);
      ls_wait();
      ls_req = 1'b0;
      repeat (3) tick();

      // sustained contention: LSU capped at MAXS grants before IF is forced in
      gq.delete();
      fork
         do_if(2, 0);
         do_ls(8, 0);
      join
      check("cont_cnt", 64'(gq.size()), 64'd10);
      for (int i = 0; i < 10 && i < gq.size(); i++)
         check($sformatf("cont_order%0d", i), 64'(gq[i]), 64'((i % 5) != 4));
      repeat (3) tick();

      // randomized traffic
      rnd = 1; spur = 1;
      repeat (2) tick();
      fork
         do_if(30, 4);
         do_ls(50, 4);
      join
      repeat (10) tick();
      check("ifq_empty", 64'(ifq.size()), 64'd0);
      check("lsq_empty", 64'(lsq.size()), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
